// File: rtl/data_pipe_interconnect_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | data_pipe_interconnect_pkg: shared types for interconnect blocks    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package data_pipe_interconnect_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stage_state_e;

endpackage
`default_nettype wire

// File: rtl/data_inf.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | data_inf: valid/ready stream with data payload                      |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
interface data_inf #(
  parameter int DSIZE = 8
) ();
  logic             valid;
  logic             ready;
  logic [DSIZE-1:0] data;

  modport master (output valid, output data, input ready);
  modport slaver (input valid, input data, output ready);
endinterface
`default_nettype wire

// File: rtl/data_pipe_rr_arb.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | data_pipe_rr_arb: round-robin grant, pointer moves only on accept   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module data_pipe_rr_arb #(
  parameter int NUM = 8
) (
  input  logic                    clock,
  input  logic                    rst_n,
  input  logic [NUM-1:0]          req,
  input  logic                    accept,
  output logic [NUM-1:0]          grant,
  output logic [$clog2(NUM)-1:0]  grant_idx
);

  localparam int c_NSIZE = $clog2(NUM);
  localparam int c_POS_W = c_NSIZE + 1;

  logic [c_NSIZE-1:0] r_last;
  logic [c_POS_W-1:0] w_pos;
  logic               w_found;

  // Search starts just past the last winner and wraps at NUM, not 2^NSIZE.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    w_found   = 1'b0;
    w_pos     = '0;
    for (int k = 1; k <= NUM; k++) begin
      w_pos = {1'b0, r_last} + c_POS_W'(k);
      if (w_pos >= c_POS_W'(NUM)) begin
        w_pos = w_pos - c_POS_W'(NUM);
      end
      if (!w_found && req[w_pos[c_NSIZE-1:0]]) begin
        w_found                    = 1'b1;
        grant[w_pos[c_NSIZE-1:0]]  = 1'b1;
        grant_idx                  = w_pos[c_NSIZE-1:0];
      end
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= c_NSIZE'(NUM - 1);
    end else if (accept) begin
      r_last <= grant_idx;
    end
  end

endmodule
`default_nettype wire

// File: rtl/data_pipe_interconnect_m2s_rr.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | data_pipe_interconnect_m2s_rr: NUM-to-1 round-robin stream merge    |
// | with a two-entry registered output stage. Rev 1.0                   |
// +--------------------------------------------------------------------+
module data_pipe_interconnect_m2s_rr
  import data_pipe_interconnect_pkg::*;
#(
  parameter int DSIZE  = 8,
  parameter int NUM    = 8,
  parameter int NSIZE  = $clog2(NUM),
  parameter int LAZISE = 1
) (
  input  logic                         clock,
  input  logic                         rst_n,
  input  logic                         clk_en,
  data_inf.slaver                      s00 [NUM-1:0],
  input  logic [NUM-1:0][LAZISE-1:0]   s00_lazy_data,
  data_inf.master                      m00,
  output logic [LAZISE-1:0]            m00_lazy_data,
  output logic [NSIZE-1:0]             m00_src
);

  localparam int c_ENTRY_W = DSIZE + LAZISE + NSIZE;

  logic [NUM-1:0]             w_req;
  logic [NUM-1:0][DSIZE-1:0]  w_s_data;
  logic [NUM-1:0]             w_grant;
  logic [NSIZE-1:0]           w_idx;
  logic [c_ENTRY_W-1:0]       w_in;
  logic                       w_up;
  logic                       w_down;
  stage_state_e               w_nstate;

  stage_state_e               r_state;
  logic                       r_up_ready;
  logic [c_ENTRY_W-1:0]       r_main;
  logic [c_ENTRY_W-1:0]       r_skid;

  for (genvar i = 0; i < NUM; i++) begin : g_unroll
    assign w_req[i]    = s00[i].valid;
    assign w_s_data[i] = s00[i].data;
    assign s00[i].ready = r_up_ready & w_grant[i];
  end

  data_pipe_rr_arb #(
    .NUM (NUM)
  ) u_arb (
    .clock     (clock),
    .rst_n     (rst_n),
    .req       (w_req),
    .accept    (w_up),
    .grant     (w_grant),
    .grant_idx (w_idx)
  );

  // Grant is non-zero exactly when some request is present.
  assign w_up   = r_up_ready & (|w_req) & clk_en;
  assign w_down = (r_state != EMPTY) & m00.ready & clk_en;
  assign w_in   = {w_s_data[w_idx], s00_lazy_data[w_idx], w_idx};

  always_comb begin
    w_nstate = r_state;
    case (r_state)
      EMPTY: if (w_up) w_nstate = ONE;
      ONE: begin
        if (w_up && !w_down)      w_nstate = TWO;
        else if (!w_up && w_down) w_nstate = EMPTY;
      end
      TWO:     if (w_down) w_nstate = ONE;
      default: w_nstate = EMPTY;
    endcase
  end

  // Ready is registered from the next state, so a full stage never
  // sees another up-transfer and the skid entry can never overflow.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= EMPTY;
      r_up_ready <= 1'b0;
      r_main     <= '0;
      r_skid     <= '0;
    end else if (clk_en) begin
      r_state    <= w_nstate;
      r_up_ready <= (w_nstate != TWO);
      case (r_state)
        EMPTY: if (w_up) r_main <= w_in;
        ONE: begin
          if (w_up && !w_down)     r_skid <= w_in;
          else if (w_up && w_down) r_main <= w_in;
        end
        TWO:     if (w_down) r_main <= r_skid;
        default: r_main <= r_main;
      endcase
    end
  end

  assign m00.valid     = (r_state != EMPTY);
  assign m00.data      = r_main[c_ENTRY_W-1 -: DSIZE];
  assign m00_lazy_data = r_main[NSIZE +: LAZISE];
  assign m00_src       = r_main[NSIZE-1:0];

endmodule
`default_nettype wire

// File: tb/tb_data_pipe_interconnect_m2s_rr.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_data_pipe_interconnect_m2s_rr: directed bench, NUM=8 and NUM=5   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_data_pipe_interconnect_m2s_rr;

  logic clk;
  logic rst_a_n;
  logic rst_b_n;
  logic clk_en;

  logic [7:0]            a_valid;
  logic [7:0][7:0]       a_data;
  logic [7:0][0:0]       a_lazy;
  logic                  a_m_ready;
  wire  [7:0]            a_ready;
  wire                   a_m_valid;
  wire  [7:0]            a_m_data;
  wire  [0:0]            a_m_lazy;
  wire  [2:0]            a_m_src;

  logic [4:0]            b_valid;
  logic [4:0][7:0]       b_data;
  logic [4:0][0:0]       b_lazy;
  wire  [4:0]            b_ready;
  wire                   b_m_valid;
  wire  [7:0]            b_m_data;
  wire  [0:0]            b_m_lazy;
  wire  [2:0]            b_m_src;

  int errors = 0;
  int checks = 0;

  data_inf #(.DSIZE(8)) sa [7:0] ();
  data_inf #(.DSIZE(8)) ma ();
  data_inf #(.DSIZE(8)) sb [4:0] ();
  data_inf #(.DSIZE(8)) mb ();

  for (genvar i = 0; i < 8; i++) begin : g_sa
    assign sa[i].valid = a_valid[i];
    assign sa[i].data  = a_data[i];
    assign a_ready[i]  = sa[i].ready;
  end
  for (genvar i = 0; i < 5; i++) begin : g_sb
    assign sb[i].valid = b_valid[i];
    assign sb[i].data  = b_data[i];
    assign b_ready[i]  = sb[i].ready;
  end
  assign ma.ready  = a_m_ready;
  assign a_m_valid = ma.valid;
  assign a_m_data  = ma.data;
  assign mb.ready  = 1'b1;
  assign b_m_valid = mb.valid;
  assign b_m_data  = mb.data;

  data_pipe_interconnect_m2s_rr #(
    .DSIZE(8), .NUM(8), .NSIZE(3), .LAZISE(1)
  ) u_dut_a (
    .clock         (clk),
    .rst_n         (rst_a_n),
    .clk_en        (clk_en),
    .s00           (sa),
    .s00_lazy_data (a_lazy),
    .m00           (ma),
    .m00_lazy_data (a_m_lazy),
    .m00_src       (a_m_src)
  );

  data_pipe_interconnect_m2s_rr #(
    .DSIZE(8), .NUM(5), .NSIZE(3), .LAZISE(1)
  ) u_dut_b (
    .clock         (clk),
    .rst_n         (rst_b_n),
    .clk_en        (clk_en),
    .s00           (sb),
    .s00_lazy_data (b_lazy),
    .m00           (mb),
    .m00_lazy_data (b_m_lazy),
    .m00_src       (b_m_src)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clk       = 1'b0;
    rst_a_n   = 1'b0;
    rst_b_n   = 1'b0;
    clk_en    = 1'b1;
    a_m_ready = 1'b1;
    a_valid   = 8'hFF;
    b_valid   = 5'h1F;
    for (int i = 0; i < 8; i++) begin
      a_data[i] = 8'(17 * i);
      a_lazy[i] = 1'(i % 2);
    end
    for (int i = 0; i < 5; i++) begin
      b_data[i] = 8'(17 * i);
      b_lazy[i] = 1'(i % 2);
    end

    // Reset values
    step();
    step();
    check("rst_ready", 32'(a_ready), 32'h00);
    check("rst_valid", 32'(a_m_valid), 32'h0);
    check("rst_data", 32'(a_m_data), 32'h00);
    check("rst_src", 32'(a_m_src), 32'h0);
    check("rst_lazy", 32'(a_m_lazy), 32'h0);
    check("b_rst_valid", 32'(b_m_valid), 32'h0);

    // Release: ready rises one enabled cycle later, first grant to input 0
    rst_a_n = 1'b1;
    check("ready_pre", 32'(a_ready), 32'h00);
    step();
    check("ready_first", 32'(a_ready), 32'h01);
    check("valid_first", 32'(a_m_valid), 32'h0);

    // All valid, full throughput: src 0..7,0
    for (int j = 0; j < 9; j++) begin
      step();
      check("rr_valid", 32'(a_m_valid), 32'h1);
      check("rr_src", 32'(a_m_src), 32'(j % 8));
      check("rr_data", 32'(a_m_data), 32'(17 * (j % 8)));
      check("rr_lazy", 32'(a_m_lazy), 32'((j % 8) % 2));
    end

    // Only inputs 2 and 5 valid
    a_valid = 8'b0010_0100;
    for (int j = 0; j < 4; j++) begin
      step();
      check("alt_src", 32'(a_m_src), (j % 2 == 0) ? 32'd2 : 32'd5);
      check("alt_data", 32'(a_m_data), (j % 2 == 0) ? 32'h22 : 32'h55);
    end

    // Drain, then backpressure with input 3 streaming
    a_valid = 8'h00;
    step();
    check("drain_valid", 32'(a_m_valid), 32'h0);

    a_valid   = 8'h08;
    a_data[3] = 8'h30;
    a_m_ready = 1'b0;
    step();
    check("bp0_data", 32'(a_m_data), 32'h30);
    check("bp0_src", 32'(a_m_src), 32'd3);
    check("bp0_ready", 32'(a_ready), 32'h08);
    a_data[3] = 8'h31;
    step();
    check("bp1_ready", 32'(a_ready), 32'h00);
    check("bp1_data", 32'(a_m_data), 32'h30);
    a_data[3] = 8'h32;
    step();
    check("bp2_ready", 32'(a_ready), 32'h00);
    check("bp2_data", 32'(a_m_data), 32'h30);
    check("bp2_valid", 32'(a_m_valid), 32'h1);
    a_m_ready = 1'b1;
    step();
    check("bp3_data", 32'(a_m_data), 32'h31);
    check("bp3_ready", 32'(a_ready), 32'h08);
    step();
    check("bp4_data", 32'(a_m_data), 32'h32);
    a_valid = 8'h00;
    step();
    check("bp5_valid", 32'(a_m_valid), 32'h0);

    // clk_en 1,0,1 with every handshake condition true
    a_data[3] = 8'h33;
    a_valid   = 8'hFF;
    step();
    check("en1_src", 32'(a_m_src), 32'd4);
    check("en1_data", 32'(a_m_data), 32'h44);
    clk_en = 1'b0;
    step();
    check("en0_src", 32'(a_m_src), 32'd4);
    check("en0_data", 32'(a_m_data), 32'h44);
    check("en0_valid", 32'(a_m_valid), 32'h1);
    check("en0_ready", 32'(a_ready), 32'h20);
    clk_en = 1'b1;
    step();
    check("en2_src", 32'(a_m_src), 32'd5);
    check("en2_data", 32'(a_m_data), 32'h55);

    // Fill to TWO, then async reset mid-cycle
    a_m_ready = 1'b0;
    step();
    check("two_ready", 32'(a_ready), 32'h00);
    check("two_src", 32'(a_m_src), 32'd5);
    #2;
    rst_a_n = 1'b0;
    #1;
    check("arst_valid", 32'(a_m_valid), 32'h0);
    check("arst_data", 32'(a_m_data), 32'h00);
    check("arst_ready", 32'(a_ready), 32'h00);
    step();
    rst_a_n   = 1'b1;
    a_m_ready = 1'b1;
    step();
    check("arst_grant", 32'(a_ready), 32'h01);
    step();
    check("arst_src", 32'(a_m_src), 32'd0);
    check("arst_out", 32'(a_m_data), 32'h00);

    // NUM=5 instance: wraps 4 -> 0
    rst_b_n = 1'b1;
    check("b_ready_pre", 32'(b_ready), 32'h00);
    step();
    check("b_ready_first", 32'(b_ready), 32'h01);
    for (int j = 0; j < 7; j++) begin
      step();
      check("b_valid", 32'(b_m_valid), 32'h1);
      check("b_src", 32'(b_m_src), 32'(j % 5));
      check("b_data", 32'(b_m_data), 32'(17 * (j % 5)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
